// File: rtl/ucr_hash_nonce_ctrl.sv
// ucr_hash_nonce_ctrl
// Nonce-search sequencer for one micro_ucr_hash round core. It latches the
// header/target/range on start, runs LAST_ROUND rounds per nonce, checks H,
// and reports the first hit or the last nonce tried when the range runs out.
module ucr_hash_nonce_ctrl #(
   parameter int LAST_ROUND = 33,
   parameter int CNT_W      = 6
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              start,
   input  logic              abort,
   input  logic [95:0]       header,
   input  logic [7:0]        target,
   input  logic [31:0]       nonce_start,
   input  logic [31:0]       nonce_limit,
   input  logic [23:0]       H,
   output logic [CNT_W-1:0]  counter,
   output logic              fin,
   output logic [127:0]      bloque_in,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [31:0]       nonce_out,
   output logic [23:0]       hash_out,
   output logic [31:0]       attempts
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LAST_ROUND);
   localparam logic [CNT_W-1:0] CNT_CHECK = CNT_W'(LAST_ROUND + 1);

   logic [1:0]  state;
   logic [95:0] header_q;
   logic [31:0] nonce_q;
   logic [7:0]  target_q;
   logic [31:0] limit_q;

   // The core only accumulates while rounds run; every other state freezes H.
   always_comb begin
      fin       = (state != S_RUN);
      bloque_in = {header_q, nonce_q};
   end

   // Search sequencing: round counting, per-nonce check, abort and result capture.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state     <= S_IDLE;
         counter   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         found     <= 1'b0;
         nonce_out <= '0;
         hash_out  <= '0;
         attempts  <= '0;
         header_q  <= '0;
         nonce_q   <= '0;
         target_q  <= '0;
         limit_q   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               counter <= '0;
               if (start) begin
                  header_q <= header;
                  target_q <= target;
                  limit_q  <= nonce_limit;
                  nonce_q  <= nonce_start;
                  attempts <= '0;
                  found    <= 1'b0;
                  busy     <= 1'b1;
                  counter  <= CNT_ONE;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state     <= S_IDLE;
                  counter   <= '0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  found     <= 1'b0;
                  nonce_out <= nonce_q;
               end else if (counter == CNT_LAST) begin
                  state   <= S_CHECK;
                  counter <= CNT_CHECK;
               end else begin
                  counter <= counter + CNT_ONE;
               end
            end
            S_CHECK: begin
               // Abort wins over a same-cycle hit and does not count as an attempt.
               if (abort) begin
                  state     <= S_IDLE;
                  counter   <= '0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  found     <= 1'b0;
                  nonce_out <= nonce_q;
               end else begin
                  attempts <= attempts + 32'd1;
                  if (H[23:16] < target_q) begin
                     state     <= S_IDLE;
                     counter   <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     found     <= 1'b1;
                     nonce_out <= nonce_q;
                     hash_out  <= H;
                  end else if (nonce_q == limit_q) begin
                     state     <= S_IDLE;
                     counter   <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     found     <= 1'b0;
                     nonce_out <= nonce_q;
                     hash_out  <= H;
                  end else begin
                     nonce_q <= nonce_q + 32'd1;
                     counter <= CNT_ONE;
                     state   <= S_RUN;
                  end
               end
            end
            default: begin
               state   <= S_IDLE;
               counter <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ucr_hash_nonce_ctrl.sv
module tb_ucr_hash_nonce_ctrl;

  logic         clk = 1'b0;
  logic         reset_L;
  logic         start;
  logic         abort;
  logic [95:0]  header;
  logic [7:0]   target;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_limit;
  logic [23:0]  H;
  logic [5:0]   counter;
  logic         fin;
  logic [127:0] bloque_in;
  logic         busy;
  logic         done;
  logic         found;
  logic [31:0]  nonce_out;
  logic [23:0]  hash_out;
  logic [31:0]  attempts;

  int checks = 0;
  int errors = 0;

  ucr_hash_nonce_ctrl #(.LAST_ROUND(33), .CNT_W(6)) dut (
    .clk(clk), .reset_L(reset_L), .start(start), .abort(abort),
    .header(header), .target(target), .nonce_start(nonce_start),
    .nonce_limit(nonce_limit), .H(H), .counter(counter), .fin(fin),
    .bloque_in(bloque_in), .busy(busy), .done(done), .found(found),
    .nonce_out(nonce_out), .hash_out(hash_out), .attempts(attempts)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] step(input logic [23:0] h, input logic [127:0] b,
                                       input logic [5:0] r);
    logic [23:0] x;
    x = {h[20:0], h[23:21]} ^ b[23:0] ^ {b[31:24], b[111:96]} ^ b[127:104];
    return (x + {r, r, r, r}) ^ {b[55:48], b[79:64]};
  endfunction

  function automatic logic [23:0] model_hash(input logic [127:0] b);
    logic [23:0] h;
    h = step(24'h0189FE, b, 6'd1);
    for (int unsigned r = 2; r <= 33; r++) h = step(h, b, 6'(r));
    return h;
  endfunction

  logic [23:0] h_core = '0;
  always @(posedge clk) begin
    if (!fin) begin
      if (counter == 6'd1) h_core <= step(24'h0189FE, bloque_in, 6'd1);
      else                 h_core <= step(h_core, bloque_in, counter);
    end
  end
  assign H = h_core;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [95:0] hd, input logic [7:0] tg,
                          input logic [31:0] ns, input logic [31:0] nl);
    header = hd; target = tg; nonce_start = ns; nonce_limit = nl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [95:0] hdr;
  logic [23:0] exp_h;
  logic [31:0] exp_n, exp_att;
  logic        exp_f;
  int          cyc;

  initial begin
    reset_L = 1'b0; start = 1'b0; abort = 1'b0;
    header = '0; target = '0; nonce_start = '0; nonce_limit = '0;
    #2;
    checks++; if (counter !== 6'd0) begin errors++; $error("FAIL rst_counter: %0h", counter); end
    checks++; if (fin !== 1'b1) begin errors++; $error("FAIL rst_fin: %0h", fin); end
    checks++; if (busy !== 1'b0) begin errors++; $error("FAIL rst_busy: %0h", busy); end
    checks++; if (done !== 1'b0) begin errors++; $error("FAIL rst_done: %0h", done); end
    checks++; if (found !== 1'b0) begin errors++; $error("FAIL rst_found: %0h", found); end
    checks++; if (bloque_in !== 128'd0) begin errors++; $error("FAIL rst_bloque: %0h", bloque_in); end
    checks++; if (attempts !== 32'd0) begin errors++; $error("FAIL rst_attempts: %0h", attempts); end
    tick(); tick();
    reset_L = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      checks++; if (counter !== 6'd0) begin errors++; $error("FAIL idle_counter: %0h", counter); end
      checks++; if (fin !== 1'b1) begin errors++; $error("FAIL idle_fin: %0h", fin); end
    end

    hdr = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
    do_start(hdr, 8'hFF, 32'd5, 32'd5);
    for (int unsigned k = 1; k <= 33; k++) begin
      checks++; if (counter !== 6'(k)) begin errors++; $error("FAIL hit_counter: %0h exp %0h", counter, k); end
      checks++; if (fin !== 1'b0) begin errors++; $error("FAIL hit_fin_run: %0h", fin); end
      checks++; if (busy !== 1'b1) begin errors++; $error("FAIL hit_busy_run: %0h", busy); end
      if (k < 33) tick();
    end
    tick();
    checks++; if (counter !== 6'd34) begin errors++; $error("FAIL hit_check_counter: %0h", counter); end
    checks++; if (fin !== 1'b1) begin errors++; $error("FAIL hit_check_fin: %0h", fin); end
    checks++; if (busy !== 1'b1) begin errors++; $error("FAIL hit_check_busy: %0h", busy); end
    checks++; if (done !== 1'b0) begin errors++; $error("FAIL hit_check_done: %0h", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $error("FAIL hit_done: %0h", done); end
    checks++; if (found !== 1'b1) begin errors++; $error("FAIL hit_found: %0h", found); end
    checks++; if (nonce_out !== 32'd5) begin errors++; $error("FAIL hit_nonce: %0h", nonce_out); end
    checks++; if (attempts !== 32'd1) begin errors++; $error("FAIL hit_attempts: %0h", attempts); end
    checks++; if (hash_out !== model_hash({hdr, 32'd5})) begin errors++; $error("FAIL hit_hash: %0h", hash_out); end
    checks++; if (busy !== 1'b0) begin errors++; $error("FAIL hit_busy_done: %0h", busy); end
    checks++; if (counter !== 6'd0) begin errors++; $error("FAIL hit_counter_idle: %0h", counter); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $error("FAIL hit_done_width: %0h", done); end
    checks++; if (found !== 1'b1) begin errors++; $error("FAIL hit_found_held: %0h", found); end

    hdr = 96'hA5A5_0000_FFFF_1234_5678_9ABC;
    do_start(hdr, 8'h00, 32'd10, 32'd13);
    for (int unsigned n = 0; n < 4; n++) begin
      checks++; if (bloque_in[31:0] !== 32'(10 + n)) begin errors++; $error("FAIL exh_nonce_step: %0h", bloque_in[31:0]); end
      checks++; if (counter !== 6'd1) begin errors++; $error("FAIL exh_counter1: %0h", counter); end
      checks++; if (done !== 1'b0) begin errors++; $error("FAIL exh_done_low: %0h", done); end
      repeat (34) tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $error("FAIL exh_done: %0h", done); end
    checks++; if (found !== 1'b0) begin errors++; $error("FAIL exh_found: %0h", found); end
    checks++; if (nonce_out !== 32'd13) begin errors++; $error("FAIL exh_nonce: %0h", nonce_out); end
    checks++; if (attempts !== 32'd4) begin errors++; $error("FAIL exh_attempts: %0h", attempts); end
    checks++; if (hash_out !== model_hash({hdr, 32'd13})) begin errors++; $error("FAIL exh_hash: %0h", hash_out); end

    tick();
    hdr = 96'h1111_2222_3333_4444_5555_6666;
    do_start(hdr, 8'h00, 32'hFFFF_FFFE, 32'd1);
    for (int unsigned n = 0; n < 4; n++) begin
      checks++; if (bloque_in[31:0] !== 32'hFFFF_FFFE + 32'(n)) begin errors++; $error("FAIL wrap_nonce_step: %0h", bloque_in[31:0]); end
      repeat (34) tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $error("FAIL wrap_done: %0h", done); end
    checks++; if (found !== 1'b0) begin errors++; $error("FAIL wrap_found: %0h", found); end
    checks++; if (nonce_out !== 32'd1) begin errors++; $error("FAIL wrap_nonce: %0h", nonce_out); end
    checks++; if (attempts !== 32'd4) begin errors++; $error("FAIL wrap_attempts: %0h", attempts); end
    exp_h = model_hash({hdr, 32'd1});
    checks++; if (hash_out !== exp_h) begin errors++; $error("FAIL wrap_hash: %0h", hash_out); end

    tick();
    hdr = 96'hDEAD_BEEF_0000_0001_CAFE_F00D;
    do_start(hdr, 8'h00, 32'd100, 32'd200);
    repeat (19) tick();
    header = '0; nonce_start = 32'd999; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $error("FAIL abt_busy_ignored_start: %0h", busy); end
    repeat (14) tick();
    checks++; if (bloque_in[31:0] !== 32'd101) begin errors++; $error("FAIL abt_second_nonce: %0h", bloque_in[31:0]); end
    checks++; if (bloque_in[127:32] !== hdr) begin errors++; $error("FAIL abt_header_kept: %0h", bloque_in[127:32]); end
    repeat (15) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $error("FAIL abt_done: %0h", done); end
    checks++; if (found !== 1'b0) begin errors++; $error("FAIL abt_found: %0h", found); end
    checks++; if (nonce_out !== 32'd101) begin errors++; $error("FAIL abt_nonce: %0h", nonce_out); end
    checks++; if (busy !== 1'b0) begin errors++; $error("FAIL abt_busy: %0h", busy); end
    checks++; if (counter !== 6'd0) begin errors++; $error("FAIL abt_counter: %0h", counter); end
    checks++; if (fin !== 1'b1) begin errors++; $error("FAIL abt_fin: %0h", fin); end
    checks++; if (attempts !== 32'd1) begin errors++; $error("FAIL abt_attempts: %0h", attempts); end
    checks++; if (hash_out !== exp_h) begin errors++; $error("FAIL abt_hash_kept: %0h", hash_out); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $error("FAIL abt_done_width: %0h", done); end

    hdr = {$urandom, $urandom, $urandom};
    exp_f = 1'b0; exp_n = 32'd149; exp_att = 32'd150;
    for (int unsigned n = 0; n < 150; n++) begin
      if (!exp_f && model_hash({hdr, 32'(n)}) < 24'h140000) begin
        exp_f = 1'b1; exp_n = 32'(n); exp_att = 32'(n + 1);
      end
    end
    do_start(hdr, 8'd20, 32'd0, 32'd149);
    cyc = 0;
    while (done !== 1'b1 && cyc < 150 * 34 + 20) begin
      tick();
      cyc++;
    end
    checks++; if (done !== 1'b1) begin errors++; $error("FAIL done_within_budget: %0h", done); end
    checks++; if (cyc !== 34 * int'(exp_att)) begin errors++; $error("FAIL srch_latency: %0d", cyc); end
    checks++; if (found !== exp_f) begin errors++; $error("FAIL srch_found: %0h", found); end
    checks++; if (nonce_out !== exp_n) begin errors++; $error("FAIL srch_nonce: %0h", nonce_out); end
    checks++; if (attempts !== exp_att) begin errors++; $error("FAIL srch_attempts: %0h", attempts); end
    checks++; if (hash_out !== model_hash({hdr, exp_n})) begin errors++; $error("FAIL srch_hash: %0h", hash_out); end

    tick();
    do_start(hdr, 8'h00, 32'd7, 32'd50);
    repeat (40) tick();
    #2;
    reset_L = 1'b0;
    #1;
    checks++; if (counter !== 6'd0) begin errors++; $error("FAIL mrst_counter: %0h", counter); end
    checks++; if (fin !== 1'b1) begin errors++; $error("FAIL mrst_fin: %0h", fin); end
    checks++; if (busy !== 1'b0) begin errors++; $error("FAIL mrst_busy: %0h", busy); end
    checks++; if (found !== 1'b0) begin errors++; $error("FAIL mrst_found: %0h", found); end
    checks++; if (nonce_out !== 32'd0) begin errors++; $error("FAIL mrst_nonce_out: %0h", nonce_out); end
    checks++; if (hash_out !== 24'd0) begin errors++; $error("FAIL mrst_hash_out: %0h", hash_out); end
    checks++; if (attempts !== 32'd0) begin errors++; $error("FAIL mrst_attempts: %0h", attempts); end
    checks++; if (bloque_in !== 128'd0) begin errors++; $error("FAIL mrst_bloque: %0h", bloque_in); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $error("FAIL mrst_no_done: %0h", done); end
    reset_L = 1'b1;
    repeat (3) tick();
    checks++; if (counter !== 6'd0) begin errors++; $error("FAIL mrst_idle_counter: %0h", counter); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucr_hash_nonce_ctrl.md
# ucr_hash_nonce_ctrl

Sequencer that drives the `micro_ucr_hash` round core through a nonce search. It latches a 96-bit block header and an 8-bit difficulty target, then generates the core's `counter`, `fin` and `bloque_in` for each nonce. After every pass it checks the core's `H` output and stops on the first hash whose top byte is below target, or when the nonce range runs out. It sits between the mining front-end (start/result handshake) and one hash core.

## Interface
Parameters:
- `LAST_ROUND`, 33: final round count value; `H` is valid one cycle later.
- `CNT_W`, 6: width of the `counter` output.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_L` in 1: reset, asynchronous, active-low.
- `start` in 1: begin search; sampled only in IDLE.
- `abort` in 1: terminate the search; ignored in IDLE.
- `header` in 96: block header; latched on accepted `start`.
- `target` in 8: difficulty; latched on accepted `start`.
- `nonce_start` in 32: first nonce to try; latched on accepted `start`.
- `nonce_limit` in 32: last nonce to try, inclusive; latched on accepted `start`.
- `H` in 24: hash from the core.
- `counter` out CNT_W: round counter to the core.
- `fin` out 1: to the core. 0 only while rounds run; 1 freezes `H` accumulation.
- `bloque_in` out 128: to the core, `{header_q, nonce_q}`; the nonce occupies bits [31:0].
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the search ends.
- `found` out 1: valid with `done`, held until the next accepted `start`.
- `nonce_out` out 32: winning nonce, or last nonce tried.
- `hash_out` out 24: `H` of the nonce in `nonce_out`.
- `attempts` out 32: number of nonces checked in this search.

## Operation
- States: IDLE, RUN, CHECK.
- Reset (async, `reset_L`=0):
  - State IDLE.
  - `counter`=0, `fin`=1.
  - `busy`=`done`=`found`=0.
  - `nonce_out`=`hash_out`=`attempts`=0.
  - Internal `header_q`=0, `nonce_q`=0, `target_q`=0, `limit_q`=0; hence `bloque_in`=0.
- IDLE:
  - `counter`=0, `fin`=1.
  - On `start`: latch inputs, `nonce_q`←`nonce_start`, `attempts`←0, `found`←0, `busy`←1, `counter`←1, go to RUN.
- RUN:
  - `fin`=0, `counter` increments by 1 per cycle.
  - When `counter`==LAST_ROUND, next state is CHECK with `counter`←LAST_ROUND+1.
  - `counter`=1 makes the core clear `H` and load W from `bloque_in`.
  - `bloque_in` is stable throughout RUN.
- CHECK (`counter`=LAST_ROUND+1, `fin`=1, `H` final). Do `attempts`←`attempts`+1, then apply in priority order:
  1. Hit (`H[23:16]` < `target_q`, unsigned): `found`←1, `nonce_out`←`nonce_q`, `hash_out`←`H`, pulse `done`, `busy`←0, `counter`←0, go to IDLE.
  2. Exhausted (`nonce_q`==`limit_q`): `found`←0, `nonce_out`←`nonce_q`, `hash_out`←`H`, pulse `done`, go to IDLE.
  3. Otherwise: `nonce_q`←`nonce_q`+1 (32-bit, wraps at FFFFFFFF→0), `counter`←1, go to RUN.
- `target`=0 never hits, so the full range is searched.
- `nonce_limit` < `nonce_start` is legal: the search wraps through 0 until it reaches the limit.
- `abort` in RUN or CHECK:
  - Next state IDLE, `counter`←0, `fin`=1, `busy`←0, `done` pulses, `found`←0.
  - `nonce_out`←`nonce_q`, `hash_out` unchanged.
  - `abort` takes priority over a same-cycle hit.
- `start` while busy is ignored.
- Hold `start` high across `done` to restart immediately from IDLE on the following cycle.
- Reset mid-search: immediate return to reset values; no `done` pulse.

## Timing
- Accepted `start` at edge T:
  - `counter`=1 during cycle T+1.
  - `counter`=LAST_ROUND during cycle T+33.
  - CHECK during cycle T+34.
- First-attempt result: `done`/`found`/`nonce_out`/`hash_out` are registered, visible in cycle T+35.
- Each miss costs 34 cycles. Attempt n (0-based) is in CHECK in cycle T+34+34n.
- `busy` is high in cycles T+1 through the CHECK cycle that ends the search; low in the cycle `done` is high.
- `done` is exactly one cycle wide.
- `attempts` is updated in the same cycle as `done`.

## Test plan
- Reset then idle: hold `reset_L`=0 mid-cycle → all outputs 0 and `fin`=1 immediately, asynchronously; idle for 10 cycles with `start`=0 → `counter` stays 0.
- Immediate hit: `target`=FF, `nonce_start`=`nonce_limit`=5, `start` at T → `counter` 1..33 over T+1..T+33, `done` at T+35 with `found`=1, `nonce_out`=5, `attempts`=1, `hash_out` equal to the reference-model hash of `{header,5}`.
- Exhaust: `target`=0, `nonce_start`=10, `nonce_limit`=13 → `done` at T+1+34·4 with `found`=0, `nonce_out`=13, `attempts`=4; `bloque_in[31:0]` steps 10,11,12,13.
- Wrap: `target`=0, start=FFFFFFFE, limit=1 → nonces FFFFFFFE, FFFFFFFF, 0, 1 tried; `attempts`=4.
- Abort: `abort` pulsed at T+50 → `done` at T+51 with `found`=0, `nonce_out`=`nonce_start`+1; `start` during the search is ignored.
- Search against the model: random header, `target`=20 → the first nonce whose model hash has top byte < 20 is reported, and `attempts` equals its offset+1.
